// File: rtl/cim_pkg.sv
// Shared CIM definitions: default geometry of the weight bank and the weight loader state encoding.
package cim_pkg;

   localparam int WEIGHT_BITS = 12;
   localparam int ROWS        = 144;
   localparam int ADDR_WIDTH  = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      FILL      = 2'd2,
      WAIT_SWAP = 2'd3
   } wload_state_t;

endpackage

// File: rtl/cim_weight_loader_if.sv
// Weight stream handshake between the weight DMA/FIFO (master) and the loader (slave).
// Carries an even-parity bit when WLOAD_PARITY_CHECK_EN is defined.
interface cim_weight_loader_if #(
   parameter int WEIGHT_BITS = cim_pkg::WEIGHT_BITS
);
   logic                   valid;
   logic                   ready;
   logic [WEIGHT_BITS-1:0] data;
   logic                   last;
`ifdef WLOAD_PARITY_CHECK_EN
   logic                   par;

   modport master (output valid, data, last, par, input ready);
   modport slave  (input valid, data, last, par, output ready);
`else
   modport master (output valid, data, last, input ready);
   modport slave  (input valid, data, last, output ready);
`endif
endinterface

// File: rtl/cim_wload_rowctr.sv
// Tile row counter: synchronous clear, increment that stops at the last row, last-row flag.
module cim_wload_rowctr
   import cim_pkg::*;
#(
   parameter int ROWS       = cim_pkg::ROWS,
   parameter int ADDR_WIDTH = cim_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  inc,
   output logic [ADDR_WIDTH-1:0] count,
   output logic                  is_last
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !is_last) begin
         // Holding at the last row keeps the address inside the tile; only clr restarts it.
         count <= count + ADDR_WIDTH'(1);
      end
   end

   assign is_last = (count == LAST_ROW);

endmodule

// File: rtl/cim_weight_loader.sv
// Weight loader: fills the shadow (non-MAC) bank row from a valid/ready stream, then requests a swap.
// Optional even-parity checking of incoming words is built when WLOAD_PARITY_CHECK_EN is defined.
module cim_weight_loader
   import cim_pkg::*;
#(
   parameter int WEIGHT_BITS = cim_pkg::WEIGHT_BITS,
   parameter int ROWS        = cim_pkg::ROWS,
   parameter int ADDR_WIDTH  = cim_pkg::ADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   mac_on_pong_row,
   cim_weight_loader_if.slave     s,
   output logic                   we,
   output logic [ADDR_WIDTH-1:0]  wa,
   output logic [WEIGHT_BITS-1:0] d_in,
   output logic                   write_to_pong_row,
   output logic                   swap_req,
   input  logic                   swap_ack,
   output logic                   busy,
   output logic                   done,
   output logic                   err_len
`ifdef WLOAD_PARITY_CHECK_EN
   ,
   output logic                   err_par
`endif
);

   wload_state_t           state, next_state;
   logic                   s_ready_q;
   logic                   beat, start_ok;
   logic                   ctr_clr, ctr_inc, ctr_last;
   logic [ADDR_WIDTH-1:0]  ctr_count;
   logic                   we_d, pong_d, err_len_d, done_d;
   logic [ADDR_WIDTH-1:0]  wa_d;
   logic [WEIGHT_BITS-1:0] d_d;

   cim_wload_rowctr #(
      .ROWS       (ROWS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rowctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (ctr_clr),
      .inc     (ctr_inc),
      .count   (ctr_count),
      .is_last (ctr_last)
   );

   assign s.ready = s_ready_q;
   assign beat    = (state == LOAD) && s.valid && s_ready_q;
   // The done cycle already shows IDLE, but a start there belongs to the finished tile's handoff.
   assign start_ok = (state == IDLE) && start && !done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         state <= next_state;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      next_state = state;
      ctr_clr    = 1'b0;
      ctr_inc    = 1'b0;
      we_d       = 1'b0;
      wa_d       = wa;
      d_d        = d_in;
      pong_d     = write_to_pong_row;
      err_len_d  = err_len;
      done_d     = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) begin
               pong_d     = ~mac_on_pong_row;
               ctr_clr    = 1'b1;
               err_len_d  = 1'b0;
               next_state = LOAD;
            end
         end
         LOAD: begin
            if (beat) begin
               we_d = 1'b1;
               wa_d = ctr_count;
               d_d  = s.data;
               if (ctr_last) begin
                  next_state = WAIT_SWAP;
                  if (!s.last) err_len_d = 1'b1;
               end else begin
                  ctr_inc = 1'b1;
                  if (s.last) begin
                     err_len_d  = 1'b1;
                     next_state = FILL;
                  end
               end
            end
         end
         FILL: begin
            // Pad the rest of a short tile with zero weights, one row per cycle.
            we_d = 1'b1;
            wa_d = ctr_count;
            d_d  = '0;
            if (ctr_last) next_state = WAIT_SWAP;
            else          ctr_inc    = 1'b1;
         end
         WAIT_SWAP: begin
            if (swap_ack) begin
               done_d     = 1'b1;
               next_state = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ready_q         <= 1'b0;
         we                <= 1'b0;
         wa                <= '0;
         d_in              <= '0;
         write_to_pong_row <= 1'b0;
         swap_req          <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         err_len           <= 1'b0;
      end else begin
         s_ready_q         <= (next_state == LOAD);
         we                <= we_d;
         wa                <= wa_d;
         d_in              <= d_d;
         write_to_pong_row <= pong_d;
         swap_req          <= (next_state == WAIT_SWAP);
         busy              <= (next_state != IDLE);
         done              <= done_d;
         err_len           <= err_len_d;
      end
   end

`ifdef WLOAD_PARITY_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_par <= 1'b0;
      end else if (start_ok) begin
         err_par <= 1'b0;
      end else if (beat && ((^s.data) != s.par)) begin
         err_par <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_cim_weight_loader.sv
// Self-checking bench for cim_weight_loader: table of tile scenarios plus reset and handoff sequences.
module tb_cim_weight_loader;
   import cim_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start = 1'b0;
   logic                   mac_on_pong_row = 1'b0;
   logic                   swap_ack = 1'b0;
   logic                   we, write_to_pong_row, swap_req, busy, done, err_len;
   logic [ADDR_WIDTH-1:0]  wa;
   logic [WEIGHT_BITS-1:0] d_in;
`ifdef WLOAD_PARITY_CHECK_EN
   logic                   err_par;
`endif

   cim_weight_loader_if #(.WEIGHT_BITS(WEIGHT_BITS)) s_if ();

   cim_weight_loader dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .mac_on_pong_row   (mac_on_pong_row),
      .s                 (s_if),
      .we                (we),
      .wa                (wa),
      .d_in              (d_in),
      .write_to_pong_row (write_to_pong_row),
      .swap_req          (swap_req),
      .swap_ack          (swap_ack),
      .busy              (busy),
      .done              (done),
      .err_len           (err_len)
`ifdef WLOAD_PARITY_CHECK_EN
      ,
      .err_par           (err_par)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Write monitor: records every bank write seen on the falling edge.
   int                    cyc = 0;
   int                    wr_total = 0;
   logic [ADDR_WIDTH-1:0] wr_wa  [4096];
   logic [WEIGHT_BITS-1:0] wr_d  [4096];
   int                    wr_cyc [4096];
   logic                  wr_rdy [4096];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && we === 1'b1 && wr_total < 4096) begin
         wr_wa[wr_total]  = wa;
         wr_d[wr_total]   = d_in;
         wr_cyc[wr_total] = cyc;
         wr_rdy[wr_total] = s_if.ready;
         wr_total++;
      end
   end

   function automatic logic [WEIGHT_BITS-1:0] pat(input int idx, input int k);
      return WEIGHT_BITS'((idx * 256 + k) % 4096);
   endfunction

   typedef struct {
      bit mac;
      int last_pos;      // beat index carrying s_last, -1 for none
      int n_offer;       // beats offered
      bit gaps;          // s_valid only on every other cycle
      int ack_delay;     // cycles in WAIT_SWAP before swap_ack
      bit disturb;       // flip mac, pulse start and swap_ack at beat 20
      bit start_on_done; // pulse start in the done cycle
      bit bad_par;       // corrupt parity of beat 7
      int exp_beats;     // beats the loader must accept
      bit exp_err_len;
   } vec_t;

   vec_t vecs [8];

   task automatic drive_beat(input int idx, input int k, input vec_t v);
      s_if.valid = 1'b1;
      s_if.data  = pat(idx, k);
      s_if.last  = (k == v.last_pos);
`ifdef WLOAD_PARITY_CHECK_EN
      s_if.par   = (^pat(idx, k)) ^ (v.bad_par && k == 7);
`endif
   endtask

   task automatic run_tile(input int idx, input vec_t v);
      int  base, k, budget;
      bit  offer, pend, dist_done;
      base = wr_total;
      @(negedge clk);
      mac_on_pong_row = v.mac;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("v%0d busy_after_start", idx), busy, 1);
      check($sformatf("v%0d ready_after_start", idx), s_if.ready, 1);
      check($sformatf("v%0d pong_latched", idx), write_to_pong_row, !v.mac);
      check($sformatf("v%0d err_len_cleared", idx), err_len, 0);
`ifdef WLOAD_PARITY_CHECK_EN
      check($sformatf("v%0d err_par_cleared", idx), err_par, 0);
`endif

      k = 0; budget = 0; dist_done = 0;
      while (k < v.n_offer && swap_req !== 1'b1 && budget < 3000) begin
         offer = !v.gaps || (budget % 2 == 0);
         drive_beat(idx, k, v);
         s_if.valid = offer;
         if (v.disturb && k == 20 && !dist_done) begin
            mac_on_pong_row = !v.mac;
            start = 1'b1;
            swap_ack = 1'b1;
            dist_done = 1;
         end else begin
            start = 1'b0;
            swap_ack = 1'b0;
         end
         pend = offer && (s_if.ready === 1'b1);
         @(negedge clk);
         if (pend) k++;
         budget++;
      end
      s_if.valid = 1'b0;
      start = 1'b0;
      swap_ack = 1'b0;
      while (swap_req !== 1'b1 && budget < 3000) begin
         @(negedge clk);
         budget++;
      end
      check($sformatf("v%0d swap_req", idx), swap_req, 1);
      check($sformatf("v%0d beats_accepted", idx), k, v.exp_beats);

      // A stray beat offered while waiting for the swap must be refused.
      for (int j = 0; j < v.ack_delay; j++) begin
         drive_beat(idx, 200, v);
         @(negedge clk);
         check($sformatf("v%0d wait_ready", idx), s_if.ready, 0);
         check($sformatf("v%0d wait_we", idx), we, 0);
         check($sformatf("v%0d wait_swap_req", idx), swap_req, 1);
      end
      s_if.valid = 1'b0;
      swap_ack = 1'b1;
      @(negedge clk);
      swap_ack = 1'b0;
      if (v.start_on_done) start = 1'b1;
      check($sformatf("v%0d done_pulse", idx), done, 1);
      check($sformatf("v%0d swap_req_dropped", idx), swap_req, 0);
      @(negedge clk);
      start = 1'b0;
      check($sformatf("v%0d done_single", idx), done, 0);
      check($sformatf("v%0d idle_busy", idx), busy, 0);
      check($sformatf("v%0d idle_ready", idx), s_if.ready, 0);
      check($sformatf("v%0d pong_hold", idx), write_to_pong_row, !v.mac);
      check($sformatf("v%0d err_len", idx), err_len, v.exp_err_len);
`ifdef WLOAD_PARITY_CHECK_EN
      check($sformatf("v%0d err_par", idx), err_par, v.bad_par);
`endif

      check($sformatf("v%0d write_count", idx), wr_total - base, ROWS);
      for (int i = 0; i < ROWS; i++) begin
         check($sformatf("v%0d wa[%0d]", idx, i), wr_wa[base+i], i);
         check($sformatf("v%0d d_in[%0d]", idx, i), wr_d[base+i],
               (i < v.exp_beats) ? pat(idx, i) : '0);
         if (i >= v.exp_beats && i > 0) begin
            check($sformatf("v%0d fill_consec[%0d]", idx, i), wr_cyc[base+i] - wr_cyc[base+i-1], 1);
            check($sformatf("v%0d fill_ready[%0d]", idx, i), wr_rdy[base+i], 0);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, s_if.ready, 0);
      check({tag, "_we"}, we, 0);
      check({tag, "_wa"}, wa, 0);
      check({tag, "_d_in"}, d_in, 0);
      check({tag, "_pong"}, write_to_pong_row, 0);
      check({tag, "_swap_req"}, swap_req, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err_len"}, err_len, 0);
`ifdef WLOAD_PARITY_CHECK_EN
      check({tag, "_err_par"}, err_par, 0);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  k, budget;
      bit  pend;
      vec_t v_rst;

      //            mac  last  offer gaps ack dist sod  par  beats err
      vecs[0] = '{1'b0, 143, 144, 1'b0, 5, 1'b0, 1'b0, 1'b0, 144, 1'b0}; // normal tile
      vecs[1] = '{1'b0,  99, 100, 1'b0, 3, 1'b0, 1'b0, 1'b0, 100, 1'b1}; // short tile
      vecs[2] = '{1'b1, 143, 144, 1'b1, 2, 1'b0, 1'b0, 1'b0, 144, 1'b0}; // backpressure
      vecs[3] = '{1'b1,  -1, 145, 1'b0, 1, 1'b0, 1'b0, 1'b0, 144, 1'b1}; // missing s_last
      vecs[4] = '{1'b0, 142, 143, 1'b1, 0, 1'b0, 1'b0, 1'b0, 143, 1'b1}; // one row short
      vecs[5] = '{1'b1,   0,   1, 1'b0, 2, 1'b0, 1'b1, 1'b0,   1, 1'b1}; // s_last on first beat
      vecs[6] = '{1'b0, 143, 144, 1'b0, 1, 1'b1, 1'b0, 1'b1, 144, 1'b0}; // latch/ignored start
      vecs[7] = '{1'b1, 143, 144, 1'b1, 0, 1'b0, 1'b0, 1'b0, 144, 1'b0}; // after mid-load reset

      s_if.valid = 1'b0;
      s_if.data  = '0;
      s_if.last  = 1'b0;
`ifdef WLOAD_PARITY_CHECK_EN
      s_if.par   = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      swap_ack = 1'b1;
      @(negedge clk);
      swap_ack = 1'b0;
      @(negedge clk);
      check("idle_ack_done", done, 0);
      check("idle_ack_busy", busy, 0);
      check("idle_ack_swap_req", swap_req, 0);

      for (int i = 0; i < 7; i++) run_tile(i, vecs[i]);

      // Reset in the middle of a load: everything clears at once, no swap request follows.
      v_rst = vecs[0];
      @(negedge clk);
      mac_on_pong_row = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0; budget = 0;
      while (k < 50 && budget < 500) begin
         drive_beat(9, k, v_rst);
         pend = (s_if.ready === 1'b1);
         @(negedge clk);
         if (pend) k++;
         budget++;
      end
      check("rst_mid_beats", k, 50);
      check("rst_mid_wa_before", wa, 49);
      check("rst_mid_pong_before", write_to_pong_row, 1);
      #1 rst_n = 1'b0;
      #1 check_all_zero("rst_mid_async");
      s_if.valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_swap_req", swap_req, 0);
      check("rst_mid_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("rst_mid_release");

      run_tile(7, vecs[7]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
